// File: rtl/sdrx_block.sv
// SD data-line receive framer: start-bit hunt, 1/4/8-lane byte assembly into 32-bit words,
// per-lane CRC16 residual check, end-bit check and start-bit timeout.
module sdrx_block #(
  parameter int LGLEN     = 15,
  parameter int NUMIO     = 8,
  parameter int LGTIMEOUT = 23
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_en,
  input  logic [1:0]           i_width,
  input  logic [LGLEN-1:0]     i_length,
  input  logic [LGTIMEOUT-1:0] i_timeout,
  input  logic                 i_stb,
  input  logic [NUMIO-1:0]     i_data,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [31:0]          o_data,
  output logic                 o_last,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_CRC, S_END, S_DONE} state_t;

  state_t               state, state_d;
  logic [1:0]           wsel, wsel_in;
  logic [LGLEN-1:0]     len, bytes, bytes_inc;
  logic [2:0]           bpos, bstep;
  logic [7:0]           sreg, byte_next, dpad, mask;
  logic [31:0]          word, word_next;
  logic [3:0]           ccnt;
  logic [LGTIMEOUT-1:0] tcnt;
  logic [15:0]          crc [8];
  logic                 byte_done, last_byte, start_bit, end_ok, crc_bad, emit;
  logic                 done_err, done_tmo;

  // Requested width clamped to the lanes physically present
  always_comb begin
    wsel_in = 2'd0;
    if (i_width == 2'd2 && NUMIO >= 8)
      wsel_in = 2'd2;
    else if ((i_width == 2'd1 || i_width == 2'd2) && NUMIO >= 4)
      wsel_in = 2'd1;
  end

  always_comb begin
    dpad = '0;
    dpad[NUMIO-1:0] = i_data;
  end

  always_comb begin
    unique case (wsel)
      2'd1:    begin mask = 8'h0F; byte_next = {sreg[3:0], dpad[3:0]};   bstep = 3'd4; end
      2'd2:    begin mask = 8'hFF; byte_next = dpad;                     bstep = 3'd0; end
      default: begin mask = 8'h01; byte_next = {sreg[6:0], dpad[0]};     bstep = 3'd1; end
    endcase
  end

  assign byte_done = (wsel == 2'd2) || (wsel == 2'd1 && bpos == 3'd4) || (wsel == 2'd0 && bpos == 3'd7);
  assign bytes_inc = bytes + LGLEN'(1);
  assign last_byte = (bytes_inc == len);
  // Bytes land at their final lane of the word, so a short final word is already left-justified
  assign word_next = word | ({byte_next, 24'h0} >> {bytes[1:0], 3'b000});
  assign start_bit = i_stb && ((dpad & mask) == 8'h00);
  assign end_ok    = ((dpad | ~mask) == 8'hFF);
  assign emit      = (state == S_DATA) && i_en && i_stb && byte_done && (last_byte || bytes_inc[1:0] == 2'b00);

  always_comb begin
    crc_bad = 1'b0;
    for (int unsigned i = 0; i < 8; i++)
      if (mask[i] && crc[i] != 16'h0000) crc_bad = 1'b1;
  end

  always_comb begin
    state_d  = state;
    done_err = 1'b0;
    done_tmo = 1'b0;
    unique case (state)
      S_IDLE: if (i_en) state_d = S_WAIT;
      S_WAIT: begin
        if (!i_en)
          state_d = S_IDLE;
        else if (start_bit)
          state_d = (len == '0) ? S_CRC : S_DATA;
        else if (i_timeout != '0 && tcnt == i_timeout - LGTIMEOUT'(1)) begin
          state_d  = S_DONE;
          done_err = 1'b1;
          done_tmo = 1'b1;
        end
      end
      S_DATA: begin
        if (!i_en) state_d = S_IDLE;
        else if (i_stb && byte_done && last_byte) state_d = S_CRC;
      end
      S_CRC: begin
        if (!i_en) state_d = S_IDLE;
        else if (i_stb && ccnt == 4'd15) state_d = S_END;
      end
      S_END: begin
        if (!i_en) state_d = S_IDLE;
        else if (i_stb) begin
          state_d  = S_DONE;
          done_err = crc_bad | ~end_ok;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_d;
  end

  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wsel <= '0; len <= '0; bytes <= '0; bpos <= '0; sreg <= '0;
      word <= '0; ccnt <= '0; tcnt <= '0;
      for (int unsigned i = 0; i < 8; i++) crc[i] <= '0;
      o_valid <= 1'b0; o_data <= '0; o_last <= 1'b0;
      o_done <= 1'b0; o_err <= 1'b0; o_timeout <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      if (state == S_IDLE && state_d == S_WAIT) begin
        wsel <= wsel_in; len <= i_length;
        bytes <= '0; bpos <= '0; sreg <= '0; word <= '0; ccnt <= '0; tcnt <= '0;
        for (int unsigned i = 0; i < 8; i++) crc[i] <= '0;
      end
      if (state == S_WAIT && tcnt != '1)
        tcnt <= tcnt + LGTIMEOUT'(1);
      if ((state == S_DATA || state == S_CRC) && i_en && i_stb)
        for (int unsigned i = 0; i < 8; i++)
          crc[i] <= {crc[i][14:0], 1'b0} ^ ((crc[i][15] ^ dpad[i]) ? 16'h1021 : 16'h0000);
      if (state == S_DATA && i_en && i_stb) begin
        sreg <= byte_next;
        bpos <= bpos + bstep;
        if (byte_done) begin
          bytes <= bytes_inc;
          word  <= emit ? '0 : word_next;
        end
      end
      if (emit) begin
        o_valid <= 1'b1;
        o_data  <= word_next;
        o_last  <= last_byte;
      end
      if (state == S_CRC && i_en && i_stb)
        ccnt <= ccnt + 4'd1;
      if (state_d == S_DONE && state != S_DONE) begin
        o_done    <= 1'b1;
        o_err     <= done_err;
        o_timeout <= done_tmo;
      end
    end
  end

endmodule

// File: tb/tb_sdrx_block.sv
// Directed self-checking bench for sdrx_block: 1/4/8-lane blocks, CRC/end-bit errors,
// start-bit timeout, async reset, abort and strobe gaps.
module tb_sdrx_block;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_en = 1'b0;
  logic [1:0]  i_width = '0;
  logic [14:0] i_length = '0;
  logic [22:0] i_timeout = '0;
  logic        i_stb = 1'b0;
  logic [7:0]  i_data = '0;
  logic        o_busy, o_valid, o_last, o_done, o_err, o_timeout;
  logic [31:0] o_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  blk [512];
  logic [31:0] exp_w [$];
  logic [31:0] got_w [$];
  logic        got_l [$];
  int          done_cnt = 0;
  logic        got_err = 1'b0;
  logic        got_tmo = 1'b0;

  sdrx_block #(.LGLEN(15), .NUMIO(8), .LGTIMEOUT(23)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en), .i_width(i_width),
    .i_length(i_length), .i_timeout(i_timeout), .i_stb(i_stb), .i_data(i_data),
    .o_busy(o_busy), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
    .o_done(o_done), .o_err(o_err), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    #1;
    if (o_valid) begin
      got_w.push_back(o_data);
      got_l.push_back(o_last);
    end
    if (o_done) begin
      done_cnt++;
      got_err = o_err;
      got_tmo = o_timeout;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic clear_mon();
    got_w.delete(); got_l.delete(); done_cnt = 0; got_err = 1'b0; got_tmo = 1'b0;
  endtask

  // Entered on a negedge; leaves on the negedge where the next sample may be driven
  task automatic strobe(input logic [7:0] d, input int gap);
    i_stb = 1'b1; i_data = d;
    @(negedge i_clk);
    if (gap > 0) begin
      i_stb = 1'b0; i_data = 8'($urandom);
      repeat (gap) @(negedge i_clk);
    end
  endtask

  task automatic send_block(input int wc, input int nbytes, input int nstop, input int gap,
                            input int flip_lane, input logic [7:0] end_bad,
                            input logic use_ovr, input logic [15:0] ovr0);
    int w;
    logic [15:0] crc_l [8];
    logic [7:0] d, idle_hi, bv;
    w = (wc == 2) ? 8 : (wc == 1) ? 4 : 1;
    idle_hi = (w == 8) ? 8'h00 : (w == 4) ? 8'hF0 : 8'hFE;
    for (int i = 0; i < 8; i++) crc_l[i] = '0;
    @(negedge i_clk);
    strobe(8'hFF, gap);
    strobe(8'hFF, gap);
    strobe(idle_hi, gap);
    for (int b = 0; b < nbytes && b < nstop; b++) begin
      bv = blk[b];
      if (w == 8) begin
        d = bv;
        for (int i = 0; i < w; i++) crc_l[i] = crc_step(crc_l[i], d[i]);
        strobe(d, gap);
      end else if (w == 4) begin
        for (int h = 1; h >= 0; h--) begin
          d = idle_hi | {4'h0, bv[h*4 +: 4]};
          for (int i = 0; i < w; i++) crc_l[i] = crc_step(crc_l[i], d[i]);
          strobe(d, gap);
        end
      end else begin
        for (int k = 7; k >= 0; k--) begin
          d = idle_hi | {7'h0, bv[k]};
          crc_l[0] = crc_step(crc_l[0], d[0]);
          strobe(d, gap);
        end
      end
    end
    if (nstop >= nbytes) begin
      if (use_ovr) crc_l[0] = ovr0;
      for (int k = 15; k >= 0; k--) begin
        d = idle_hi;
        for (int i = 0; i < w; i++) d[i] = crc_l[i][k] ^ ((i == flip_lane) && (k == 3));
        strobe(d, gap);
      end
      strobe(8'hFF & ~end_bad, gap);
    end
    i_stb = 1'b0;
  endtask

  task automatic run_block(input int wc, input int nbytes, input int gap, input int flip_lane,
                           input logic [7:0] end_bad, input logic use_ovr, input logic [15:0] ovr0);
    clear_mon();
    i_width = 2'(wc); i_length = 15'(nbytes); i_timeout = '0;
    i_en = 1'b1;
    send_block(wc, nbytes, nbytes, gap, flip_lane, end_bad, use_ovr, ovr0);
    for (int n = 0; n < 50 && done_cnt == 0; n++) @(negedge i_clk);
    i_en = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic check_result(input string tag, input logic exp_err, input logic exp_tmo);
    check({tag, "_nwords"}, 32'(got_w.size()), 32'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
      check($sformatf("%s_word%0d", tag, k), got_w[k], exp_w[k]);
      check($sformatf("%s_last%0d", tag, k), 32'(got_l[k]), 32'(k == exp_w.size() - 1));
    end
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_err"}, 32'(got_err), 32'(exp_err));
    check({tag, "_tmo"}, 32'(got_tmo), 32'(exp_tmo));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge i_clk);
    #1;
    check("rst_busy",  32'(o_busy),    32'd0);
    check("rst_valid", 32'(o_valid),   32'd0);
    check("rst_data",  o_data,         32'd0);
    check("rst_done",  32'(o_done),    32'd0);
    check("rst_err",   32'(o_err | o_timeout | o_last), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // 1-bit, 512 bytes of 0xFF with its known CRC
    for (int b = 0; b < 512; b++) blk[b] = 8'hFF;
    exp_w.delete();
    for (int k = 0; k < 128; k++) exp_w.push_back(32'hFFFF_FFFF);
    run_block(0, 512, 0, -1, 8'h00, 1'b1, 16'h7FA1);
    check_result("w1_512", 1'b0, 1'b0);

    // 4-bit, 8 bytes
    for (int b = 0; b < 8; b++) blk[b] = 8'(b * 8'h22 + 8'h01);
    exp_w = '{32'h0123_4567, 32'h89AB_CDEF};
    run_block(1, 8, 0, -1, 8'h00, 1'b0, 16'h0);
    check_result("w4_8", 1'b0, 1'b0);

    // 8-bit, 6 bytes, one CRC bit flipped on lane 5
    for (int b = 0; b < 6; b++) blk[b] = 8'((b + 1) * 8'h11);
    exp_w = '{32'h1122_3344, 32'h5566_0000};
    run_block(2, 6, 0, 5, 8'h00, 1'b0, 16'h0);
    check_result("w8_crcerr", 1'b1, 1'b0);

    // 4-bit, correct CRC, end bit low on DAT2
    blk[0] = 8'hDE; blk[1] = 8'hAD; blk[2] = 8'hBE; blk[3] = 8'hEF;
    exp_w = '{32'hDEAD_BEEF};
    run_block(1, 4, 0, -1, 8'h04, 1'b0, 16'h0);
    check_result("w4_endbad", 1'b1, 1'b0);

    // Start-bit timeout of 100 cycles
    clear_mon();
    i_width = 2'd0; i_length = 15'd4; i_timeout = 23'd100;
    i_en = 1'b1;
    @(posedge i_clk);
    n = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge i_clk); #1;
      if (c == 1) check("tmo_busy", 32'(o_busy), 32'd1);
      if (o_done) begin n = c; break; end
    end
    check("tmo_cycle", 32'(n), 32'd100);
    check("tmo_err", 32'(o_err), 32'd1);
    check("tmo_flag", 32'(o_timeout), 32'd1);
    @(negedge i_clk);
    i_en = 1'b0; i_timeout = '0;
    repeat (2) @(negedge i_clk);
    check("tmo_nvalid", 32'(got_w.size()), 32'd0);

    // 8-bit, 16 bytes, gap-free reference
    for (int b = 0; b < 16; b++) blk[b] = 8'(8'hA0 + b);
    exp_w = '{32'hA0A1_A2A3, 32'hA4A5_A6A7, 32'hA8A9_AAAB, 32'hACAD_AEAF};
    run_block(2, 16, 0, -1, 8'h00, 1'b0, 16'h0);
    check_result("w8_16", 1'b0, 1'b0);

    // Abort after 3 bytes
    clear_mon();
    i_width = 2'd2; i_length = 15'd16; i_en = 1'b1;
    send_block(2, 16, 3, 0, -1, 8'h00, 1'b0, 16'h0);
    i_en = 1'b0;
    repeat (5) @(negedge i_clk);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_nvalid", 32'(got_w.size()), 32'd0);
    check("abort_ndone", 32'(done_cnt), 32'd0);

    // Same 16-byte block with two idle cycles between samples
    run_block(2, 16, 2, -1, 8'h00, 1'b0, 16'h0);
    check_result("w8_16_gap", 1'b0, 1'b0);

    // Async reset in the middle of DATA
    for (int b = 0; b < 8; b++) blk[b] = 8'(b * 8'h22 + 8'h01);
    clear_mon();
    i_width = 2'd1; i_length = 15'd8; i_en = 1'b1;
    send_block(1, 8, 5, 0, -1, 8'h00, 1'b0, 16'h0);
    check("mid_busy", 32'(o_busy), 32'd1);
    check("mid_data", o_data, 32'h0123_4567);
    #2 i_reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_data", o_data, 32'd0);
    check("arst_flags", 32'({o_valid, o_last, o_done, o_err, o_timeout}), 32'd0);
    i_en = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);
    check("post_rst_busy", 32'(o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdrx_block.md
Name: sdrx_block

Overview:
Next-generation SD data-line receive framer. Hunts for the start bit on 1, 4 or 8 data lanes, then shifts in an `i_length`-byte block and packs it into 32-bit words for the DMA/FIFO side. Checks the per-lane CRC16 and the end bit, and reports completion, CRC error or start-bit timeout. Sits between the SD I/O sampler, which supplies `i_stb` and `i_data`, and the block-buffer write port.

Parameters:
- LGLEN, 15, width of the block length in bytes (max block 2^LGLEN-1 bytes).
- NUMIO, 8, number of physical data lanes; legal values 1, 4, 8.
- LGTIMEOUT, 23, width of the start-bit timeout counter.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_en  in  1  arm receiver (level); low aborts any transfer
- i_width  in  2  bus width: 0 = 1-bit, 1 = 4-bit, 2 = 8-bit, 3 = reserved (treated as 1-bit)
- i_length  in  LGLEN  block length in bytes
- i_timeout  in  LGTIMEOUT  start-bit timeout in i_clk cycles; 0 disables the timeout
- i_stb  in  1  one sample of all lanes is valid this cycle
- i_data  in  NUMIO  lane samples; lane 0 = DAT0
- o_busy  out  1  not IDLE
- o_valid  out  1  o_data holds a word (one-cycle pulse)
- o_data  out  32  packed bytes; first byte received in [31:24]
- o_last  out  1  qualifies o_valid: final word of the block
- o_done  out  1  one-cycle pulse: block finished, success or failure
- o_err  out  1  valid with o_done: CRC error, end-bit error or timeout
- o_timeout  out  1  valid with o_done: failure was a start-bit timeout

Behaviour:
- Reset: all outputs 0, state IDLE, counters and CRCs 0.
- Width latch: on IDLE->WAIT, latch width and length. A requested width wider than NUMIO clamps to NUMIO. Active lanes: w = 1, 4 or 8. Changes to i_width or i_length mid-block are ignored.
- IDLE:
  - i_en=1 -> WAIT; clear CRCs, byte count and timeout counter.
- WAIT:
  - Timeout counter increments every clock.
  - i_stb with all active lanes 0 -> DATA (start bit; not CRC'd).
  - If i_timeout != 0 and count reaches i_timeout -1 without a start bit -> DONE with o_err=1, o_timeout=1.
  - Start bit and timeout in the same cycle: start bit wins.
- DATA:
  - Each i_stb shifts w bits MSB-first into the byte shift register; a byte completes every 8/w strobes.
  - In 8-bit mode the lane-7 bit is the byte MSB. In 4-bit mode DAT3 carries the nibble MSB.
  - Every 4th byte, o_valid pulses on the clock after the completing strobe.
  - When byte count == length, go to CRC. A final partial word is emitted left-justified, unused bytes 0, with o_last=1.
  - o_last=1 also on the final full word.
  - length 0: DATA is skipped; no o_valid pulses.
- CRC:
  - Each active lane has its own CRC16-CCITT (poly 0x1021, init 0, MSB-first).
  - Next value on each i_stb while in DATA or CRC: {crc[14:0],1'b0} ^ (crc[15]^bit ? 16'h1021 : 0).
  - 16 strobes are received in CRC state; the received CRC bits feed the same register.
  - After the 16th strobe, each active lane's residual must be 0. Inactive lanes are ignored.
  - Then -> END.
- END:
  - Next i_stb samples the end bit; all active lanes must be 1.
  - -> DONE with o_err = (any active residual != 0) | (end bit bad).
- DONE:
  - o_done pulses exactly one cycle (registered, one clock after the end-bit strobe or the timeout cycle); o_err and o_timeout are held valid in that cycle.
  - Then -> IDLE. A new block needs i_en, which may still be high; re-arm happens on the following cycle.
- Abort: i_en=0 in any state except DONE -> IDLE next clock.
  - No o_done; any pending partial word is discarded.
- Strobe gaps: cycles without i_stb never advance the data, CRC or end-bit logic. Only the timeout counter runs without i_stb.
- No backpressure: the consumer must accept o_valid every cycle it fires.
- Width rules:
  - Byte count is LGLEN bits and compared for equality; no wrap.
  - Timeout counter saturates.

Test Plan:
- 1-bit, length=512, all 0xFF data, CRC bits 0x7FA1, end bit 1 -> 128 o_valid of 0xFFFFFFFF, o_last on the 128th, o_done=1, o_err=0.
- 4-bit, length=8, bytes 01 23 45 67 89 AB CD EF, correct per-lane CRCs -> o_data 0x01234567 then 0x89ABCDEF with o_last; o_done, o_err=0.
- 8-bit, length=6, one CRC bit flipped on lane 5 -> words 0x........ and a left-justified 0xXXXX0000 with o_last; o_done with o_err=1, o_timeout=0.
- i_timeout=100, no start bit -> o_done, o_err=1, o_timeout=1 at cycle 100 after arming; no o_valid.
- Correct CRC but end bit 0 on DAT2 in 4-bit mode -> o_err=1. Separately, i_reset_n low mid-DATA -> all outputs 0 immediately (async), state IDLE.
- i_en dropped after 3 bytes of a 16-byte block -> no o_valid, no o_done. Re-arm with i_stb gaps of 2 idle cycles between samples -> identical data to the gap-free run.
